// File: rtl/wb_trace_buffer.sv
// Write-back commit trace FIFO: captures WB-stage register writes and presents them
// first-word-fall-through to a consumer, dropping (and counting) events when full.
module wb_trace_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wb_valid,
  input  logic [31:0]   wb_pc,
  input  logic [4:0]    wb_reg,
  input  logic [31:0]   wb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc,
  output logic [4:0]    out_reg,
  output logic [31:0]   out_data,
  output logic [AW:0]   level,
  output logic          full,
  output logic [15:0]   overflow_cnt
);

  localparam int unsigned EntryW = 69;

  logic [EntryW-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wp_q, wp_d;
  logic [AW-1:0]     rp_q, rp_d;
  logic [AW:0]       level_q, level_d;
  logic [15:0]       ovf_q, ovf_d;

  logic push, pop, accept, drop;
  logic [EntryW-1:0] head;

  assign full      = (level_q == (AW+1)'(DEPTH));
  assign out_valid = (level_q != '0);
  assign level     = level_q;
  assign overflow_cnt = ovf_q;

  // Writes to $0 are architecturally invisible, so they never enter the trace.
  assign push   = wb_valid && (wb_reg != 5'd0);
  assign pop    = out_valid && out_ready;
  // A pop in the same cycle frees a slot, so a full buffer still accepts.
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    if (accept) begin
      wp_d = wp_q + AW'(1);
    end
    if (pop) begin
      rp_d = rp_q + AW'(1);
    end
    unique case ({accept, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
    if (drop && (ovf_q != 16'hFFFF)) begin
      ovf_d = ovf_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
      ovf_q   <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset; entries are only read while level is non-zero.
  always_ff @(posedge clk) begin
    if (reset && accept) begin
      mem_q[wp_q] <= {wb_pc, wb_reg, wb_data};
    end
  end

  always_comb begin
    head = out_valid ? mem_q[rp_q] : '0;
  end

  assign out_pc   = head[68:37];
  assign out_reg  = head[36:32];
  assign out_data = head[31:0];

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed self-checking bench for wb_trace_buffer (DEPTH = 8).
module tb_wb_trace_buffer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wb_valid = 1'b0;
  logic [31:0] wb_pc = '0;
  logic [4:0]  wb_reg = '0;
  logic [31:0] wb_data = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [4:0]  out_reg;
  logic [31:0] out_data;
  logic [AW:0] level;
  logic        full;
  logic [15:0] overflow_cnt;

  int checks = 0;
  int failures = 0;

  wb_trace_buffer #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .wb_valid     (wb_valid),
    .wb_pc        (wb_pc),
    .wb_reg       (wb_reg),
    .wb_data      (wb_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_reg      (out_reg),
    .out_data     (out_data),
    .level        (level),
    .full         (full),
    .overflow_cnt (overflow_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [68:0] got, input logic [68:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] r,
                       input logic [31:0] d);
    wb_valid = v;
    wb_pc    = pc;
    wb_reg   = r;
    wb_data  = d;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc, input logic [4:0] r,
                            input logic [31:0] d);
    check({tag, ".valid"}, 69'(out_valid), 69'(1));
    check({tag, ".pc"},    69'(out_pc),    69'(pc));
    check({tag, ".reg"},   69'(out_reg),   69'(r));
    check({tag, ".data"},  69'(out_data),  69'(d));
  endtask

  function automatic logic [31:0] ov_pc(input int i);
    return 32'h0000_4000 + 32'(4 * i);
  endfunction

  function automatic logic [31:0] ov_data(input int i);
    return 32'hA000_0000 + 32'(i);
  endfunction

  function automatic logic [31:0] st_pc(input int i);
    return 32'h0000_5000 + 32'(4 * i);
  endfunction

  function automatic logic [4:0] st_reg(input int i);
    return 5'((i % 31) + 1);
  endfunction

  function automatic logic [31:0] st_data(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  initial begin
    // Reset values
    tick();
    tick();
    reset = 1'b1;
    check("rst.valid", 69'(out_valid), 69'(0));
    check("rst.pc",    69'(out_pc),    69'(0));
    check("rst.reg",   69'(out_reg),   69'(0));
    check("rst.data",  69'(out_data),  69'(0));
    check("rst.level", 69'(level),     69'(0));
    check("rst.full",  69'(full),      69'(0));
    check("rst.ovf",   69'(overflow_cnt), 69'(0));

    // Basic ordering and fall-through latency
    drive(1'b1, 32'h3000, 5'd8, 32'h1234);
    tick();
    check_head("lat", 32'h3000, 5'd8, 32'h1234);
    drive(1'b1, 32'h3004, 5'd9, 32'hFFFF_0000);
    tick();
    drive(1'b0, '0, '0, '0);
    check("ord.level", 69'(level), 69'(2));
    check_head("ord.h0", 32'h3000, 5'd8, 32'h1234);
    out_ready = 1'b1;
    tick();
    check_head("ord.h1", 32'h3004, 5'd9, 32'hFFFF_0000);
    tick();
    check("ord.empty", 69'(out_valid), 69'(0));
    check("ord.level0", 69'(level), 69'(0));
    out_ready = 1'b0;

    // $0 writes are filtered
    drive(1'b1, 32'h3100, 5'd0, 32'hDEAD_BEEF);
    repeat (5) tick();
    drive(1'b0, '0, '0, '0);
    check("r0.level", 69'(level), 69'(0));
    check("r0.ovf",   69'(overflow_cnt), 69'(0));
    check("r0.pc",    69'(out_pc), 69'(0));

    // Mid-stream reset discards contents
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h3200 + 32'(4 * i), 5'd3, 32'(i));
      tick();
    end
    drive(1'b0, '0, '0, '0);
    check("mr.level3", 69'(level), 69'(3));
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mr.level0", 69'(level), 69'(0));
    check("mr.valid",  69'(out_valid), 69'(0));

    // Overflow: 10 pushes into 8 slots
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, ov_pc(i), 5'(i), ov_data(i));
      tick();
    end
    drive(1'b0, '0, '0, '0);
    check("ov.full",  69'(full),  69'(1));
    check("ov.level", 69'(level), 69'(8));
    check("ov.ovf",   69'(overflow_cnt), 69'(2));
    check_head("ov.h", ov_pc(1), 5'd1, ov_data(1));

    // Simultaneous push and pop while full
    drive(1'b1, ov_pc(11), 5'd11, ov_data(11));
    out_ready = 1'b1;
    tick();
    drive(1'b0, '0, '0, '0);
    out_ready = 1'b0;
    check("byp.level", 69'(level), 69'(8));
    check("byp.ovf",   69'(overflow_cnt), 69'(2));
    check("byp.full",  69'(full), 69'(1));

    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      int idx;
      idx = (k < 7) ? k + 2 : 11;
      check_head($sformatf("drain%0d", k), ov_pc(idx), 5'(idx), ov_data(idx));
      tick();
    end
    check("drain.empty", 69'(out_valid), 69'(0));
    check("drain.level", 69'(level), 69'(0));
    check("drain.ovf",   69'(overflow_cnt), 69'(2));

    // Streaming with wrap-around, out_ready held high
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, st_pc(i), st_reg(i), st_data(i));
      tick();
      check($sformatf("st%0d.level", i), 69'(level), 69'(1));
      check($sformatf("st%0d.pc", i),   69'(out_pc),   69'(st_pc(i)));
      check($sformatf("st%0d.reg", i),  69'(out_reg),  69'(st_reg(i)));
      check($sformatf("st%0d.data", i), 69'(out_data), 69'(st_data(i)));
    end
    drive(1'b0, '0, '0, '0);
    tick();
    check("st.end.level", 69'(level), 69'(0));
    check("st.end.ovf",   69'(overflow_cnt), 69'(2));
    out_ready = 1'b0;

    // Saturation: fill, then 70000 drops on top of the existing count of 2
    drive(1'b1, 32'h6000, 5'd1, 32'h5A5A_5A5A);
    repeat (8) tick();
    check("sat.full", 69'(full), 69'(1));
    repeat (65533) tick();
    check("sat.hit",  69'(overflow_cnt), 69'(16'hFFFF));
    repeat (70000 - 65533) tick();
    drive(1'b0, '0, '0, '0);
    check("sat.hold", 69'(overflow_cnt), 69'(16'hFFFF));
    check("sat.level", 69'(level), 69'(8));
    check_head("sat.h", 32'h6000, 5'd1, 32'h5A5A_5A5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
